// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// Direct-mapped branch target table with 2-bit saturating direction counters.
// The IF port gives a zero-cycle direction/target prediction for the fetch PC.
// The EX port resolves branches: it raises mispredict/redirect for the flush
// logic, trains the table and keeps saturating performance counters.

module branch_predict_unit #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 10,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  // fetch-side prediction
  input  logic             if_valid,
  input  logic [63:0]      if_pc,
  output logic             pred_taken,
  output logic [63:0]      pred_target,
  // execute-side resolution
  input  logic             ex_valid,
  input  logic [63:0]      ex_pc,
  input  logic [1:0]       ex_br_taken,
  input  logic [63:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [63:0]      ex_pred_target,
  output logic             mispredict,
  output logic [63:0]      redirect_pc,
  // performance counters
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned ENTRIES = 2 ** INDEX_W;
  localparam int unsigned TAG_LSB = INDEX_W + 2;
  localparam int unsigned TAG_MSB = TAG_LSB + TAG_W - 1;

  // Comparator result encoding; 00 and 11 both mean "not a branch".
  typedef enum logic [1:0] {
    BR_NONE      = 2'b00,
    BR_TAKEN     = 2'b01,
    BR_NOT_TAKEN = 2'b10,
    BR_RSVD      = 2'b11
  } br_code_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [63:0]       target;
    logic [1:0]        ctr;
  } entry_t;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t           table_q [ENTRIES];
  logic [CNT_W-1:0] branch_cnt_q,  branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // ---------------------------------------------------------------------------
  // IF lookup
  // ---------------------------------------------------------------------------
  logic [INDEX_W-1:0] if_idx;
  logic [TAG_W-1:0]   if_tag;
  entry_t             if_entry;
  logic               if_hit;

  assign if_idx = if_pc[INDEX_W+1:2];
  assign if_tag = if_pc[TAG_MSB:TAG_LSB];

  // Zero-cycle prediction from the registered table (same-cycle EX writes are
  // not forwarded: IF sees the old entry until the next cycle).
  always_comb begin
    if_entry    = table_q[if_idx];
    if_hit      = if_valid & if_entry.valid & (if_entry.tag == if_tag);
    pred_taken  = rstn & if_hit & if_entry.ctr[1];
    pred_target = pred_taken ? if_entry.target : 64'd0;
  end

  // ---------------------------------------------------------------------------
  // EX resolve
  // ---------------------------------------------------------------------------
  br_code_e           ex_code;
  logic               resolve;
  logic               ex_taken;
  logic [INDEX_W-1:0] ex_idx;
  logic [TAG_W-1:0]   ex_tag;
  entry_t             ex_entry;
  logic               ex_hit;
  logic               mispredict_raw;

  assign ex_code  = br_code_e'(ex_br_taken);
  assign resolve  = ex_valid & ((ex_code == BR_TAKEN) | (ex_code == BR_NOT_TAKEN));
  assign ex_taken = (ex_code == BR_TAKEN);
  assign ex_idx   = ex_pc[INDEX_W+1:2];
  assign ex_tag   = ex_pc[TAG_MSB:TAG_LSB];

  // Direction or target disagreement with what was predicted in IF.
  always_comb begin
    mispredict_raw = resolve &
                     ((ex_taken != ex_pred_taken) |
                      (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
    mispredict     = rstn & mispredict_raw;
    if (mispredict) begin
      redirect_pc = ex_taken ? ex_target : (ex_pc + 64'd4);
    end else begin
      redirect_pc = 64'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Table training: compute the single entry written this cycle
  // ---------------------------------------------------------------------------
  logic   upd_en;
  entry_t upd_entry;

  // Saturating counter step on a hit, fresh allocation on a taken miss.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    ex_entry  = table_q[ex_idx];
    ex_hit    = ex_entry.valid & (ex_entry.tag == ex_tag);
    upd_en    = 1'b0;
    upd_entry = ex_entry;
    if (resolve) begin
      if (ex_hit) begin
        upd_en = 1'b1;
        if (ex_taken) begin
          upd_entry.ctr    = (ex_entry.ctr == 2'b11) ? 2'b11 : ex_entry.ctr + 2'b01;
          upd_entry.target = ex_target;
        end else begin
          upd_entry.ctr    = (ex_entry.ctr == 2'b00) ? 2'b00 : ex_entry.ctr - 2'b01;
        end
      end else if (ex_taken) begin
        upd_en           = 1'b1;
        upd_entry.valid  = 1'b1;
        upd_entry.tag    = ex_tag;
        upd_entry.target = ex_target;
        upd_entry.ctr    = CTR_ALLOC;
      end
    end
  end

  // Table storage with full asynchronous clear.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the table is a register array, not a RAM, because every entry must
    // clear on reset; a RAM macro cannot be reset in one step.
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: 64'd0, ctr: CTR_RESET};
      end
    end else if (upd_en) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      table_q[ex_idx] <= upd_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  // Next-state for the saturating counters.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve && (branch_cnt_q != {CNT_W{1'b1}})) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (mispredict_raw && (mispred_cnt_q != {CNT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  // PC bits outside index and tag take no part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[63:TAG_MSB+1], if_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit. Counters are narrowed to 4 bits so
// their saturation point is reachable in a short run.

module tb_branch_predict_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             if_valid;
  logic [63:0]      if_pc;
  logic             pred_taken;
  logic [63:0]      pred_target;
  logic             ex_valid;
  logic [63:0]      ex_pc;
  logic [1:0]       ex_br_taken;
  logic [63:0]      ex_target;
  logic             ex_pred_taken;
  logic [63:0]      ex_pred_target;
  logic             mispredict;
  logic [63:0]      redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.INDEX_W(6), .TAG_W(10), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_br_taken    (ex_br_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  // Present one EX instruction for one cycle (from a falling edge) and settle.
  task automatic drive_ex(input logic v, input logic [63:0] pc, input logic [1:0] br,
                          input logic [63:0] tgt, input logic pt, input logic [63:0] ptg);
    @(negedge clk);
    ex_valid       = v;
    ex_pc          = pc;
    ex_br_taken    = br;
    ex_target      = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptg;
    #1;
  endtask

  // Idle EX and present a fetch PC.
  task automatic probe_if(input logic [63:0] pc);
    @(negedge clk);
    ex_valid    = 1'b0;
    ex_br_taken = 2'b00;
    if_valid    = 1'b1;
    if_pc       = pc;
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    if_valid = 1'b1; if_pc = 64'h1000;
    ex_valid = 1'b1; ex_pc = 64'h1000; ex_br_taken = 2'b01;
    ex_target = 64'h2000; ex_pred_taken = 1'b0; ex_pred_target = 64'h0;
    #12;
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL reset_pred_taken got=%0h want=0", pred_taken); end
    vectors++; if (pred_target !== 64'h0) begin miscompares++; $display("FAIL reset_pred_target got=%0h want=0", pred_target); end
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL reset_mispredict got=%0h want=0", mispredict); end
    vectors++; if (redirect_pc !== 64'h0) begin miscompares++; $display("FAIL reset_redirect got=%0h want=0", redirect_pc); end
    vectors++; if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_counters got=%0d/%0d want=0/0", branch_cnt, mispred_cnt); end
    @(negedge clk);
    ex_valid = 1'b0; ex_br_taken = 2'b00;
    rstn = 1'b1;
  endtask

  task automatic test_allocate;
    probe_if(64'h1000);
    vectors++; if (pred_taken !== 1'b0 || pred_target !== 64'h0) begin miscompares++; $display("FAIL cold_predict got=%0h/%0h want=0/0", pred_taken, pred_target); end
    drive_ex(1'b1, 64'h1000, 2'b01, 64'h2000, 1'b0, 64'h0);
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL alloc_mispredict got=%0h want=1", mispredict); end
    vectors++; if (redirect_pc !== 64'h2000) begin miscompares++; $display("FAIL alloc_redirect got=%0h want=2000", redirect_pc); end
    // IF reads the same index in the write cycle: must still see the old entry.
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL same_cycle_old_entry got=%0h want=0", pred_taken); end
    probe_if(64'h1000);
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 64'h2000) begin miscompares++; $display("FAIL alloc_predict got=%0h/%0h want=1/2000", pred_taken, pred_target); end
    vectors++; if (branch_cnt !== 4'd1 || mispred_cnt !== 4'd1) begin miscompares++; $display("FAIL alloc_counters got=%0d/%0d want=1/1", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_not_taken;
    // ctr 10 -> 01
    drive_ex(1'b1, 64'h1000, 2'b10, 64'h2000, 1'b1, 64'h2000);
    vectors++; if (mispredict !== 1'b1 || redirect_pc !== 64'h1004) begin miscompares++; $display("FAIL nt1_redirect got=%0h/%0h want=1/1004", mispredict, redirect_pc); end
    probe_if(64'h1000);
    vectors++; if (pred_taken !== 1'b0 || pred_target !== 64'h0) begin miscompares++; $display("FAIL nt1_predict got=%0h/%0h want=0/0", pred_taken, pred_target); end
    // ctr 01 -> 00, predicted not-taken correctly
    drive_ex(1'b1, 64'h1000, 2'b10, 64'h2000, 1'b0, 64'h0);
    vectors++; if (mispredict !== 1'b0 || redirect_pc !== 64'h0) begin miscompares++; $display("FAIL nt2_correct got=%0h/%0h want=0/0", mispredict, redirect_pc); end
    probe_if(64'h1000);
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL nt2_predict got=%0h want=0", pred_taken); end
    vectors++; if (branch_cnt !== 4'd3 || mispred_cnt !== 4'd2) begin miscompares++; $display("FAIL nt_counters got=%0d/%0d want=3/2", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_ctr_saturate;
    // 00 -> 01 (still not taken)
    drive_ex(1'b1, 64'h1000, 2'b01, 64'h2000, 1'b0, 64'h0);
    probe_if(64'h1000);
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL ctr01_predict got=%0h want=0", pred_taken); end
    // 01 -> 10
    drive_ex(1'b1, 64'h1000, 2'b01, 64'h2000, 1'b0, 64'h0);
    probe_if(64'h1000);
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL ctr10_predict got=%0h want=1", pred_taken); end
    // 10 -> 11, correctly predicted, same target
    drive_ex(1'b1, 64'h1000, 2'b01, 64'h2000, 1'b1, 64'h2000);
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL ctr11_correct got=%0h want=0", mispredict); end
    // 11 stays 11
    drive_ex(1'b1, 64'h1000, 2'b01, 64'h2000, 1'b1, 64'h2000);
    // 11 -> 10, still predicts taken
    drive_ex(1'b1, 64'h1000, 2'b10, 64'h2000, 1'b1, 64'h2000);
    vectors++; if (mispredict !== 1'b1 || redirect_pc !== 64'h1004) begin miscompares++; $display("FAIL sat_nt_redirect got=%0h/%0h want=1/1004", mispredict, redirect_pc); end
    probe_if(64'h1000);
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 64'h2000) begin miscompares++; $display("FAIL sat_predict got=%0h/%0h want=1/2000", pred_taken, pred_target); end
    vectors++; if (branch_cnt !== 4'd8 || mispred_cnt !== 4'd5) begin miscompares++; $display("FAIL sat_counters got=%0d/%0d want=8/5", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_target_change;
    drive_ex(1'b1, 64'h1000, 2'b01, 64'h3000, 1'b1, 64'h2000);
    vectors++; if (mispredict !== 1'b1 || redirect_pc !== 64'h3000) begin miscompares++; $display("FAIL tgt_redirect got=%0h/%0h want=1/3000", mispredict, redirect_pc); end
    probe_if(64'h1000);
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 64'h3000) begin miscompares++; $display("FAIL tgt_predict got=%0h/%0h want=1/3000", pred_taken, pred_target); end
    @(negedge clk); if_valid = 1'b0; #1;
    vectors++; if (pred_taken !== 1'b0 || pred_target !== 64'h0) begin miscompares++; $display("FAIL if_invalid got=%0h/%0h want=0/0", pred_taken, pred_target); end
    vectors++; if (branch_cnt !== 4'd9 || mispred_cnt !== 4'd6) begin miscompares++; $display("FAIL tgt_counters got=%0d/%0d want=9/6", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_ignored;
    drive_ex(1'b1, 64'h1000, 2'b00, 64'h5000, 1'b0, 64'h0);
    vectors++; if (mispredict !== 1'b0 || redirect_pc !== 64'h0) begin miscompares++; $display("FAIL ign00 got=%0h/%0h want=0/0", mispredict, redirect_pc); end
    drive_ex(1'b1, 64'h1000, 2'b11, 64'h5000, 1'b0, 64'h0);
    vectors++; if (mispredict !== 1'b0 || redirect_pc !== 64'h0) begin miscompares++; $display("FAIL ign11 got=%0h/%0h want=0/0", mispredict, redirect_pc); end
    drive_ex(1'b0, 64'h1000, 2'b01, 64'h5000, 1'b0, 64'h0);
    vectors++; if (mispredict !== 1'b0 || redirect_pc !== 64'h0) begin miscompares++; $display("FAIL ign_exinvalid got=%0h/%0h want=0/0", mispredict, redirect_pc); end
    probe_if(64'h1000);
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 64'h3000) begin miscompares++; $display("FAIL ign_table got=%0h/%0h want=1/3000", pred_taken, pred_target); end
    vectors++; if (branch_cnt !== 4'd9 || mispred_cnt !== 4'd6) begin miscompares++; $display("FAIL ign_counters got=%0d/%0d want=9/6", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_alias;
    drive_ex(1'b1, 64'h1100, 2'b01, 64'h4000, 1'b0, 64'h0);
    vectors++; if (mispredict !== 1'b1 || redirect_pc !== 64'h4000) begin miscompares++; $display("FAIL alias_redirect got=%0h/%0h want=1/4000", mispredict, redirect_pc); end
    probe_if(64'h1000);
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL alias_evicted got=%0h want=0", pred_taken); end
    probe_if(64'h1100);
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 64'h4000) begin miscompares++; $display("FAIL alias_new got=%0h/%0h want=1/4000", pred_taken, pred_target); end
  endtask

  task automatic test_back_to_back;
    drive_ex(1'b1, 64'h2008, 2'b01, 64'h2100, 1'b0, 64'h0);
    drive_ex(1'b1, 64'h2008, 2'b01, 64'h2100, 1'b0, 64'h0);
    vectors++; if (mispredict !== 1'b1 || redirect_pc !== 64'h2100) begin miscompares++; $display("FAIL b2b_redirect got=%0h/%0h want=1/2100", mispredict, redirect_pc); end
    // Not-taken at the top of the address space: fall-through wraps to 0.
    drive_ex(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 2'b10, 64'h0, 1'b1, 64'h80);
    vectors++; if (mispredict !== 1'b1 || redirect_pc !== 64'h0) begin miscompares++; $display("FAIL wrap_redirect got=%0h/%0h want=1/0", mispredict, redirect_pc); end
    probe_if(64'h2008);
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 64'h2100) begin miscompares++; $display("FAIL b2b_predict got=%0h/%0h want=1/2100", pred_taken, pred_target); end
    vectors++; if (branch_cnt !== 4'd13 || mispred_cnt !== 4'd10) begin miscompares++; $display("FAIL b2b_counters got=%0d/%0d want=13/10", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_cnt_saturate;
    for (int i = 0; i < 6; i++) begin
      drive_ex(1'b1, 64'h3000, 2'b10, 64'h0, 1'b1, 64'h3300);
    end
    probe_if(64'h3000);
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL nt_miss_no_alloc got=%0h want=0", pred_taken); end
    vectors++; if (branch_cnt !== 4'd15 || mispred_cnt !== 4'd15) begin miscompares++; $display("FAIL cnt_saturate got=%0d/%0d want=15/15", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_reset_mid;
    probe_if(64'h1100);
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL pre_reset_predict got=%0h want=1", pred_taken); end
    drive_ex(1'b1, 64'h1100, 2'b01, 64'h6000, 1'b0, 64'h0);
    rstn = 1'b0;
    #1;
    vectors++; if (pred_taken !== 1'b0 || pred_target !== 64'h0) begin miscompares++; $display("FAIL midrst_predict got=%0h/%0h want=0/0", pred_taken, pred_target); end
    vectors++; if (mispredict !== 1'b0 || redirect_pc !== 64'h0) begin miscompares++; $display("FAIL midrst_mispredict got=%0h/%0h want=0/0", mispredict, redirect_pc); end
    vectors++; if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin miscompares++; $display("FAIL midrst_counters got=%0d/%0d want=0/0", branch_cnt, mispred_cnt); end
    @(negedge clk);
    ex_valid = 1'b0; ex_br_taken = 2'b00;
    rstn = 1'b1;
    probe_if(64'h1100);
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL post_reset_predict got=%0h want=0", pred_taken); end
    vectors++; if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin miscompares++; $display("FAIL post_reset_counters got=%0d/%0d want=0/0", branch_cnt, mispred_cnt); end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_not_taken();
    test_ctr_saturate();
    test_target_change();
    test_ignored();
    test_alias();
    test_back_to_back();
    test_cnt_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Consumes the EX-stage branch comparator result (br_taken: 2'b01 taken, 2'b10 not taken, 2'b00 no branch) and feeds next-PC selection.
- Holds a direct-mapped branch target table of 2-bit saturating counters.
- Predicts direction and target for the fetch PC in IF.
- Resolves each branch in EX, raising mispredict/redirect for the flush logic, and keeps performance counters.

Parameters:
- INDEX_W, 6, table index width; ENTRIES = 2**INDEX_W.
- TAG_W, 10, tag width; tag = pc[INDEX_W+2 +: TAG_W].
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  reset; asynchronous, active-low.
- if_valid  input  1  fetch PC valid this cycle.
- if_pc  input  64  fetch PC.
- pred_taken  output  1  IF prediction: taken.
- pred_target  output  64  IF predicted target; 0 when pred_taken=0.
- ex_valid  input  1  EX holds a valid instruction; asserted exactly one cycle per instruction (pipeline drops it on stall).
- ex_pc  input  64  PC of the EX instruction.
- ex_br_taken  input  2  comparator result: 01 taken, 10 not taken, 00/11 no branch.
- ex_target  input  64  computed branch target.
- ex_pred_taken  input  1  prediction carried down the pipeline with this instruction.
- ex_pred_target  input  64  predicted target carried down the pipeline.
- mispredict  output  1  flush request.
- redirect_pc  output  64  correct next PC; valid while mispredict=1, else 0.
- branch_cnt  output  CNT_W  resolved branches.
- mispred_cnt  output  CNT_W  mispredicted branches.

Behaviour:
- Entry fields: valid, tag[TAG_W], target[64], ctr[2]. Index = pc[INDEX_W+1:2].
- Reset (rstn low, async): all valid=0, ctr=2'b01, tag/target=0, both counters=0.
- During reset: pred_taken=0, pred_target=0, mispredict=0, redirect_pc=0.
- Predict (combinational, 0-cycle):
  - hit = if_valid & valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : 0.
- A resolve is ex_valid & (ex_br_taken==01 or ex_br_taken==10); taken = (ex_br_taken==01). Codes 00 and 11 are ignored: no update, no count, no mispredict.
- Mispredict (combinational, 0-cycle, resolve only):
  - mispredict = (taken != ex_pred_taken) | (taken & ex_pred_taken & ex_target != ex_pred_target).
  - redirect_pc = taken ? ex_target : ex_pc + 4 (64-bit wrap).
- Table update, at the rising edge after a resolve:
  - On ex_pc hit: ctr saturates; taken → min(ctr+1, 3), not taken → max(ctr-1, 0).
  - On hit and taken: target is also written with ex_target.
  - On miss and taken: allocate the entry (valid=1, tag, target=ex_target, ctr=2'b10), overwriting any occupant.
  - On miss and not taken: no change.
- Counters, at the rising edge after a resolve:
  - branch_cnt += 1 on every resolve.
  - mispred_cnt += 1 when mispredict=1.
  - Both saturate at all-ones.
- Same-index IF read and EX write in one cycle: IF sees the old entry; the new value is visible the next cycle.
- if_valid=0: no prediction outputs (both 0); updates still proceed.
- rstn asserted mid-operation: the table and counters clear immediately; any in-flight update is lost.

Test Plan:
- Reset, then if_pc=0x1000 if_valid=1 → pred_taken=0, pred_target=0. Resolve ex_pc=0x1000 br_taken=01 target=0x2000 pred_taken=0 → mispredict=1, redirect_pc=0x2000. Next cycle if_pc=0x1000 → pred_taken=1, pred_target=0x2000. Counters: branch_cnt=1, mispred_cnt=1.
- Same branch resolved not-taken twice (pred per current ctr): ctr 10→01→00. First resolve → mispredict=1, redirect_pc=0x1004. Afterwards if_pc=0x1000 → pred_taken=0.
- Taken three more times from ctr=00 → ctr saturates at 11. One not-taken → ctr=10, still pred_taken=1.
- Hit with ex_pred_taken=1, ex_pred_target=0x2000, actual br_taken=01 target=0x3000 → mispredict=1, redirect_pc=0x3000; entry target becomes 0x3000.
- Ignored codes: ex_valid=1 with br_taken=00, then 11 → mispredict=0, counters and table unchanged. ex_valid=0 with br_taken=01 → no effect.
- Aliasing and reset: 0x1000 and 0x1100 (INDEX_W=6) share an index. Taken 0x1100 evicts 0x1000 → if_pc=0x1000 pred_taken=0. Pulse rstn low mid-run → pred_taken=0 immediately, counters=0.
